// File: rtl/sumador_pkg.sv
// Shared types, default sizes and operand extension for the adder/accumulator.
package sumador_pkg;

  typedef enum logic [1:0] {
    MODE_ADD      = 2'b00,
    MODE_SUB      = 2'b01,
    MODE_ACC      = 2'b10,
    MODE_ACC_LOAD = 2'b11
  } mode_e;

  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned DEF_OUT_W  = 32;
  localparam int unsigned DEF_LANES  = 4;

  // Widest result lane the extension helper can produce.
  localparam int unsigned EXT_MAX_W  = 64;

  // Extend the low data_w bits of value to EXT_MAX_W bits, sign- or zero-filled.
  // Callers truncate the result to their own lane width.
  function automatic logic [EXT_MAX_W-1:0] extend(input logic [EXT_MAX_W-1:0] value,
                                                  input int unsigned           data_w,
                                                  input logic                  is_signed);
    logic [EXT_MAX_W-1:0] ones;
    logic [EXT_MAX_W-1:0] mask;
    logic                 fill;
    ones = '1;
    mask = ~(ones << data_w);
    fill = is_signed & (|((value >> (data_w - 1)) & EXT_MAX_W'(1)));
    return fill ? (value | ~mask) : (value & mask);
  endfunction

endpackage

// File: rtl/sumador_lane.sv
// One lane: S2 arithmetic, accumulator register and sticky overflow flag.
module sumador_lane
  import sumador_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned OUT_W  = DEF_OUT_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [1:0]        mode_i,
  input  logic              is_signed_i,
  output logic [OUT_W-1:0]  out_o,
  output logic              overflow_o
);

  mode_e            mode;
  logic [OUT_W-1:0] ext_a;
  logic [OUT_W-1:0] ext_b;
  logic [OUT_W-1:0] sum;
  logic [OUT_W-1:0] diff;
  logic [OUT_W:0]   acc_wide;
  logic             acc_ovf;

  logic [OUT_W-1:0] acc_q,    acc_d;
  logic [OUT_W-1:0] out_q,    out_d;
  logic             sticky_q, sticky_d;

  // Extend operands, compute all candidate results and select by mode.
  always_comb begin
    mode     = mode_e'(mode_i);
    ext_a    = OUT_W'(extend(EXT_MAX_W'(a_i), DATA_W, is_signed_i));
    ext_b    = OUT_W'(extend(EXT_MAX_W'(b_i), DATA_W, is_signed_i));
    sum      = ext_a + ext_b;
    diff     = ext_a - ext_b;
    acc_wide = {1'b0, acc_q} + {1'b0, sum};
    // Signed overflow: both addends share a sign that the result does not.
    acc_ovf  = is_signed_i ? ((acc_q[OUT_W-1] == sum[OUT_W-1]) &&
                              (acc_wide[OUT_W-1] != acc_q[OUT_W-1]))
                           : acc_wide[OUT_W];

    acc_d    = acc_q;
    out_d    = out_q;
    sticky_d = sticky_q;
    case (mode)
      MODE_ADD: out_d = sum;
      MODE_SUB: out_d = diff;
      MODE_ACC: begin
        acc_d    = acc_wide[OUT_W-1:0];
        out_d    = acc_wide[OUT_W-1:0];
        sticky_d = sticky_q | acc_ovf;
      end
      MODE_ACC_LOAD: begin
        acc_d    = sum;
        out_d    = sum;
        sticky_d = 1'b0;
      end
      default: out_d = sum;
    endcase
  end

  // State advances only when a beat moves from S1 into S2, so stalls hold everything.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q    <= '0;
      out_q    <= '0;
      sticky_q <= 1'b0;
    end else if (en_i) begin
      acc_q    <= acc_d;
      out_q    <= out_d;
      sticky_q <= sticky_d;
    end
  end

  assign out_o      = out_q;
  assign overflow_o = sticky_q;

endmodule

// File: rtl/sumador_acumulador.sv
// Two-stage multi-lane adder/subtractor/accumulator with valid/ready on both sides.
module sumador_acumulador
  import sumador_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned OUT_W  = DEF_OUT_W,
  parameter int unsigned LANES  = DEF_LANES
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*DATA_W-1:0] operA,
  input  logic [LANES*DATA_W-1:0] operB,
  input  logic [1:0]             mode,
  input  logic                   is_signed,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*OUT_W-1:0] out,
  output logic [LANES-1:0]       overflow
);

  if (OUT_W < DATA_W + 1) begin : g_bad_out_w
    $error("sumador_acumulador: OUT_W must be at least DATA_W+1");
  end
  if (OUT_W > EXT_MAX_W) begin : g_wide_out_w
    $error("sumador_acumulador: OUT_W exceeds EXT_MAX_W");
  end
  if (LANES < 1) begin : g_no_lanes
    $error("sumador_acumulador: LANES must be at least 1");
  end

  logic                    s1_valid_q, s1_valid_d;
  logic [LANES*DATA_W-1:0] s1_a_q;
  logic [LANES*DATA_W-1:0] s1_b_q;
  mode_e                   s1_mode_q;
  logic                    s1_signed_q;
  logic                    out_valid_q, out_valid_d;

  logic s2_ready;
  logic s1_move;
  logic in_fire;

  // Handshake: each stage accepts when empty or when its content leaves this cycle.
  always_comb begin
    s2_ready    = !out_valid_q || out_ready;
    in_ready    = !rst && (!s1_valid_q || s2_ready);
    in_fire     = in_valid && in_ready;
    s1_move     = s1_valid_q && s2_ready;
    s1_valid_d  = in_ready ? in_valid : s1_valid_q;
    out_valid_d = s2_ready ? s1_valid_q : out_valid_q;
  end

  // S1 operand register and stage valids.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_mode_q   <= MODE_ADD;
      s1_signed_q <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
      if (in_fire) begin
        s1_a_q      <= operA;
        s1_b_q      <= operB;
        s1_mode_q   <= mode_e'(mode);
        s1_signed_q <= is_signed;
      end
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    sumador_lane #(
      .DATA_W(DATA_W),
      .OUT_W (OUT_W)
    ) u_lane (
      .clk_i      (clk),
      .rst_i      (rst),
      .en_i       (s1_move),
      .a_i        (s1_a_q[i*DATA_W +: DATA_W]),
      .b_i        (s1_b_q[i*DATA_W +: DATA_W]),
      .mode_i     (s1_mode_q),
      .is_signed_i(s1_signed_q),
      .out_o      (out[i*OUT_W +: OUT_W]),
      .overflow_o (overflow[i])
    );
  end

  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_sumador_acumulador.sv
// Directed-vector bench for sumador_acumulador (default 4x16->32 and a 2x16->17 instance).
module tb_sumador_acumulador;
  import sumador_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         in_valid, in_ready, out_valid, out_ready, is_signed;
  logic [63:0]  operA, operB;
  logic [1:0]   mode;
  logic [127:0] out_w;
  logic [3:0]   ovf;

  logic         in_valid2, in_ready2, out_valid2, is_signed2;
  logic [31:0]  operA2, operB2;
  logic [1:0]   mode2;
  logic [33:0]  out2;
  logic [1:0]   ovf2;

  int tests = 0;
  int fails = 0;

  sumador_acumulador dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .operA(operA), .operB(operB), .mode(mode), .is_signed(is_signed),
    .out_valid(out_valid), .out_ready(out_ready), .out(out_w), .overflow(ovf)
  );

  sumador_acumulador #(.DATA_W(16), .OUT_W(17), .LANES(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
    .operA(operA2), .operB(operB2), .mode(mode2), .is_signed(is_signed2),
    .out_valid(out_valid2), .out_ready(1'b1), .out(out2), .overflow(ovf2)
  );

  function automatic logic [127:0] pk(input logic [31:0] e0, e1, e2, e3);
    return {e3, e2, e1, e0};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] m, input logic s,
                       input logic [15:0] a0, a1, a2, a3, b0, b1, b2, b3);
    in_valid  = 1'b1;
    mode      = m;
    is_signed = s;
    operA     = {a3, a2, a1, a0};
    operB     = {b3, b2, b1, b0};
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; mode = 2'b00; is_signed = 1'b0;
    operA = '0; operB = '0;
    in_valid2 = 1'b0; mode2 = 2'b00; is_signed2 = 1'b0; operA2 = '0; operB2 = '0;
    #3;
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    tests++; if (out_w !== 128'd0) begin fails++; $display("FAIL reset_out: got %h expected 0", out_w); end
    tests++; if (ovf !== 4'd0) begin fails++; $display("FAIL reset_overflow: got %b expected 0", ovf); end
    tick;
    rst = 1'b0;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL release_in_ready: got %b expected 1", in_ready); end
    tick;
  endtask

  task automatic test_add;
    drive(MODE_ADD, 1'b0, 16'd0, 16'd4, 16'd4, 16'd4, 16'd1, 16'd10, 16'd20, 16'd32);
    tick;
    drive(MODE_ADD, 1'b1, 16'hFFFF, 16'h8000, 16'h7FFF, 16'hFFFF, 16'hFFFF, 16'h8000, 16'd1, 16'd1);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL add_latency_early: got %b expected 0", out_valid); end
    tick;
    in_valid = 1'b0;
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL add_latency: got %b expected 1", out_valid); end
    tests++; if (out_w !== pk(32'd1, 32'd14, 32'd24, 32'd36)) begin fails++; $display("FAIL add_unsigned: got %h expected %h", out_w, pk(32'd1, 32'd14, 32'd24, 32'd36)); end
    tests++; if (ovf !== 4'd0) begin fails++; $display("FAIL add_overflow: got %b expected 0", ovf); end
    tick;
    tests++; if (out_w !== pk(32'hFFFFFFFE, 32'hFFFF0000, 32'h00008000, 32'h0)) begin fails++; $display("FAIL add_signed: got %h expected %h", out_w, pk(32'hFFFFFFFE, 32'hFFFF0000, 32'h00008000, 32'h0)); end
    tick;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL add_drain: got %b expected 0", out_valid); end
  endtask

  task automatic test_sub;
    drive(MODE_SUB, 1'b1, 16'd4, 16'hFFFF, 16'h8000, 16'h7FFF, 16'd10, 16'd1, 16'd0, 16'hFFFF);
    tick;
    drive(MODE_SUB, 1'b0, 16'd4, 16'hFFFF, 16'h8000, 16'h7FFF, 16'd10, 16'd1, 16'd0, 16'hFFFF);
    tick;
    in_valid = 1'b0;
    tests++; if (out_w !== pk(32'hFFFFFFFA, 32'hFFFFFFFE, 32'hFFFF8000, 32'h00008000)) begin fails++; $display("FAIL sub_signed: got %h expected %h", out_w, pk(32'hFFFFFFFA, 32'hFFFFFFFE, 32'hFFFF8000, 32'h00008000)); end
    tick;
    tests++; if (out_w !== pk(32'hFFFFFFFA, 32'h0000FFFE, 32'h00008000, 32'hFFFF8000)) begin fails++; $display("FAIL sub_unsigned: got %h expected %h", out_w, pk(32'hFFFFFFFA, 32'h0000FFFE, 32'h00008000, 32'hFFFF8000)); end
    tick;
  endtask

  task automatic test_acc;
    drive(MODE_ACC_LOAD, 1'b0, 16'd4, 16'd4, 16'd4, 16'd4, 16'd10, 16'd10, 16'd10, 16'd10);
    tick;
    drive(MODE_ADD, 1'b0, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1);
    tick;
    tests++; if (out_w !== pk(32'd14, 32'd14, 32'd14, 32'd14)) begin fails++; $display("FAIL acc_load: got %h expected 14s", out_w); end
    drive(MODE_ACC, 1'b0, 16'd4, 16'd4, 16'd4, 16'd4, 16'd20, 16'd20, 16'd20, 16'd20);
    tick;
    tests++; if (out_w !== pk(32'd2, 32'd2, 32'd2, 32'd2)) begin fails++; $display("FAIL acc_interleaved_add: got %h expected 2s", out_w); end
    drive(MODE_ACC, 1'b0, 16'd4, 16'd4, 16'd4, 16'd4, 16'd32, 16'd32, 16'd32, 16'd32);
    tick;
    in_valid = 1'b0;
    tests++; if (out_w !== pk(32'd38, 32'd38, 32'd38, 32'd38)) begin fails++; $display("FAIL acc_second: got %h expected 38s", out_w); end
    tick;
    tests++; if (out_w !== pk(32'd74, 32'd74, 32'd74, 32'd74)) begin fails++; $display("FAIL acc_third: got %h expected 74s", out_w); end
    tests++; if (ovf !== 4'd0) begin fails++; $display("FAIL acc_overflow: got %b expected 0", ovf); end
    tick;
  endtask

  task automatic test_reset_mid;
    drive(MODE_ADD, 1'b0, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1);
    tick;
    tick;
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL midreset_pre_valid: got %b expected 1", out_valid); end
    #2;
    rst = 1'b1;
    #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL midreset_out_valid: got %b expected 0", out_valid); end
    tests++; if (out_w !== 128'd0) begin fails++; $display("FAIL midreset_out: got %h expected 0", out_w); end
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL midreset_in_ready: got %b expected 0", in_ready); end
    in_valid = 1'b0;
    tick;
    rst = 1'b0;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL midreset_release_ready: got %b expected 1", in_ready); end
    tick;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL midreset_no_pulse: got %b expected 0", out_valid); end
    drive(MODE_ACC, 1'b0, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1);
    tick;
    in_valid = 1'b0;
    tick;
    tests++; if (out_w !== pk(32'd2, 32'd2, 32'd2, 32'd2)) begin fails++; $display("FAIL midreset_acc_cleared: got %h expected 2s", out_w); end
    tick;
  endtask

  logic [1:0]  ov_m  [7] = '{MODE_ACC_LOAD, MODE_ACC, MODE_ACC, MODE_ADD, MODE_ACC_LOAD, MODE_ACC_LOAD, MODE_ACC};
  logic        ov_s  [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [15:0] ov_a0 [7] = '{16'hFFFF, 16'd1, 16'd1, 16'd1, 16'd2, 16'hFFFF, 16'd1};
  logic [15:0] ov_b0 [7] = '{16'hFFFF, 16'd0, 16'd0, 16'd1, 16'd3, 16'hFFFF, 16'd1};
  logic [15:0] ov_a1 [7] = '{16'd1, 16'd1, 16'd1, 16'd2, 16'd0, 16'h7FFF, 16'd1};
  logic [15:0] ov_b1 [7] = '{16'd1, 16'd0, 16'd0, 16'd2, 16'd0, 16'h7FFF, 16'd1};
  logic [16:0] ov_e0 [7] = '{17'h1FFFE, 17'h1FFFF, 17'h0, 17'h2, 17'h5, 17'h1FFFE, 17'h0};
  logic [16:0] ov_e1 [7] = '{17'h2, 17'h3, 17'h4, 17'h4, 17'h0, 17'h0FFFE, 17'h10000};
  logic [1:0]  ov_f  [7] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b10};

  task automatic test_overflow;
    for (int i = 0; i < 7; i++) begin
      in_valid2  = 1'b1;
      mode2      = ov_m[i];
      is_signed2 = ov_s[i];
      operA2     = {ov_a1[i], ov_a0[i]};
      operB2     = {ov_b1[i], ov_b0[i]};
      tick;
      in_valid2 = 1'b0;
      tick;
      tests++; if (out2 !== {ov_e1[i], ov_e0[i]}) begin fails++; $display("FAIL ovf_out step %0d: got %h expected %h", i, out2, {ov_e1[i], ov_e0[i]}); end
      tests++; if (ovf2 !== ov_f[i]) begin fails++; $display("FAIL ovf_flag step %0d: got %b expected %b", i, ovf2, ov_f[i]); end
    end
  endtask

  task automatic test_back_to_back;
    int           sent;
    int           got;
    logic         fire_in;
    logic         fire_out;
    logic [127:0] rec [4];
    logic [15:0]  k;
    sent = 0;
    got  = 0;
    for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
      out_ready = (cyc >= 5);
      if (sent < 4) begin
        k = 16'(sent);
        drive(MODE_ADD, 1'b0, k, k, k, k, 16'd100, 16'd100, 16'd100, 16'd100);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (cyc >= 2 && cyc < 5) begin
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL stall_in_ready cyc %0d: got %b expected 0", cyc, in_ready); end
        tests++; if (out_w !== pk(32'd100, 32'd100, 32'd100, 32'd100) || out_valid !== 1'b1) begin fails++; $display("FAIL stall_hold cyc %0d: got %h valid %b expected 100s valid 1", cyc, out_w, out_valid); end
      end
      if (cyc == 4) begin
        tests++; if (sent !== 2) begin fails++; $display("FAIL stall_accepted: got %0d expected 2", sent); end
      end
      fire_in  = in_valid && in_ready;
      fire_out = out_valid && out_ready;
      if (fire_out) rec[got] = out_w;
      @(posedge clk);
      if (fire_in) sent++;
      if (fire_out) got++;
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tests++; if (got !== 4) begin fails++; $display("FAIL b2b_count: got %0d expected 4", got); end
    for (int i = 0; i < got; i++) begin
      tests++; if (rec[i] !== pk(32'(100 + i), 32'(100 + i), 32'(100 + i), 32'(100 + i))) begin fails++; $display("FAIL b2b_order beat %0d: got %h expected lanes %0d", i, rec[i], 100 + i); end
    end
    tick;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL b2b_no_dup: got %b expected 0", out_valid); end
  endtask

  initial begin
    test_reset;
    test_add;
    test_sub;
    test_acc;
    test_reset_mid;
    test_overflow;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sumador_acumulador.md
Name: sumador_acumulador

Overview:
Parametrised, pipelined multi-lane adder/accumulator for the image datapath; successor to the combinational sumador.
- Adds or subtracts LANES independent operand pairs per beat, or accumulates their sums into per-lane running totals (pixel/window sums).
- Sits between the pixel fetch stage and the MIPS-visible result registers.
- Uses valid/ready handshakes on both sides.

Parameters:
DATA_W, 16, width of each operand lane
OUT_W, 32, width of each result/accumulator lane; must satisfy OUT_W >= DATA_W+1 (elaboration-time assertion)
LANES, 4, number of independent lanes, >= 1

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  input beat valid
in_ready  out  1  block can accept a beat
operA  in  LANES*DATA_W  lane i at bits [i*DATA_W +: DATA_W]
operB  in  LANES*DATA_W  same packing as operA
mode  in  2  00 ADD, 01 SUB, 10 ACC, 11 ACC_LOAD
is_signed  in  1  1 = operands two's complement, 0 = unsigned
out_valid  out  1  result beat valid
out_ready  in  1  downstream accepts beat
out  out  LANES*OUT_W  lane i at bits [i*OUT_W +: OUT_W]
overflow  out  LANES  per-lane sticky accumulator overflow, aligned with out

Behaviour:
- Reset (async assert, sync release in clk domain):
  - out_valid=0, out=0, overflow=0.
  - All accumulators=0; internal stage valids=0.
  - in_ready forced 0 while rst=1; it is 1 in the first cycle after release.
- Pipeline is two register stages:
  - S1 registers operands, mode and is_signed.
  - S2 computes and registers out/overflow.
- Handshake:
  - s2_ready = !out_valid | out_ready.
  - in_ready = !s1_valid | s2_ready.
  - Input fires on in_valid & in_ready; output fires on out_valid & out_ready.
- Latency and throughput:
  - Latency from input fire to out_valid is exactly 2 cycles when out_ready is held 1.
  - Throughput is 1 beat/cycle.
- Stall: while out_valid & !out_ready, out and overflow hold stable and no accumulator changes. Beats are never dropped or duplicated.
- Extension: each operand is extended to OUT_W (sign-extended if is_signed, else zero-extended) before arithmetic.
- Per-mode result, per lane:
  - ADD: out = extA + extB. Cannot overflow given the OUT_W rule. overflow output = current sticky flag, unchanged.
  - SUB: out = extA - extB, two's complement in OUT_W. Unsigned A<B yields the wrapped value, e.g. 3-5 = 0xFFFFFFFE. Sticky flag unchanged.
  - ACC: acc <= acc + (extA + extB), modulo 2^OUT_W; out = new acc value.
    - Sticky flag sets on unsigned carry-out (is_signed=0) or signed overflow (is_signed=1).
  - ACC_LOAD: acc <= extA + extB; sticky flag cleared; out = loaded value.
- Accumulator update timing: acc updates only when a beat moves from S1 into S2, so ACC beats back to back see the previous beat's result with no hazard.
- Lanes are fully independent: overflow in one lane never affects another.
- ADD/SUB beats interleaved with ACC beats do not disturb acc.
- is_signed is sampled per beat; mixing signedness across ACC beats is allowed, and the flag uses the current beat's rule.
- Reset mid-operation: in-flight beats are discarded, accumulators and flags clear, no out_valid pulse after release.

Decomposition:
- Package sumador_pkg:
  - mode_e enum (MODE_ADD, MODE_SUB, MODE_ACC, MODE_ACC_LOAD), 2 bits.
  - Default DATA_W/OUT_W/LANES localparams.
  - extend function (value, is_signed) -> OUT_W.
- Sub-module sumador_lane: one lane's S2 arithmetic, accumulator register and sticky flag, parametrised by DATA_W/OUT_W. Instantiated LANES times via generate.
- The top level owns the handshake, S1 registers and packing.

Test Plan:
- ADD, unsigned: lanes (0,1),(4,10),(4,20),(4,32), out_ready=1 -> out lanes 1,14,24,36 exactly 2 cycles after fire; overflow=0.
- SUB, signed: A=0x0004, B=0x000A -> 0xFFFFFFFA. SUB, unsigned: same operands -> 0xFFFFFFFA; A=0xFFFF, B=1 -> 0x0000FFFE.
- ACC_LOAD (4,10), then ACC (4,20), then ACC (4,32) back to back -> outputs 14, 38, 74. Preceding the sequence with ADD (1,1) leaves acc unaffected.
- Unsigned overflow: reduce OUT_W to 17 and use ACC_LOAD (0xFFFF,0xFFFF) then ACC (1,0) -> out 0x1FFFF, flag 0. A further ACC (1,0) -> out 0, flag 1. Flag stays 1 through ADD beats; ACC_LOAD clears it.
- Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 -> in_ready drops after 2 beats accepted and out holds stable. Release -> all beats delivered in order, none lost or duplicated.
- Reset: assert rst mid-stream with out_valid=1 and acc=74 -> out_valid, out, overflow and acc go 0 asynchronously. After release, ACC (1,1) -> out 2.
